// File: rtl/ref_pkg.sv
// Shared constants and widths for the DRAM refresh scheduler.
package ref_pkg;

  localparam int REF_PERIOD_DEF = 390;
  localparam int MAX_OWED_DEF   = 4;
  localparam int URG_OWED_DEF   = 2;
  localparam int URG_AGE_DEF    = 256;
  localparam int GAP_DEF        = 4;

  localparam int PCNT_W = 12;
  localparam int AGE_W  = 10;
  localparam int OWED_W = 3;
  localparam int GAP_W  = 3;

endpackage

// File: rtl/ref_prescaler.sv
// Refresh slot timer: down-counter that pulses tick for one cycle at zero and reloads.
module ref_prescaler
  import ref_pkg::*;
#(
  parameter int PERIOD = REF_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [PCNT_W-1:0] RELOAD = PCNT_W'(PERIOD - 1);

  logic [PCNT_W-1:0] pcnt;

  // Disabled counts as held at reload so the first slot after enable is a full period.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pcnt <= RELOAD;
    end else if (pcnt == '0) begin
      pcnt <= RELOAD;
    end else begin
      pcnt <= pcnt - PCNT_W'(1);
    end
  end

  assign tick = en && (pcnt == '0);

endmodule

// File: rtl/ref_sched.sv
// Refresh scheduler: tracks owed refreshes, ages pending requests, escalates to urgent,
// and holds both request outputs low for a fixed gap after every controller ack.
module ref_sched
  import ref_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int MAX_OWED   = MAX_OWED_DEF,
  parameter int URG_OWED   = URG_OWED_DEF,
  parameter int URG_AGE    = URG_AGE_DEF,
  parameter int GAP        = GAP_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RefEn,
  input  logic              RefAck,
  output logic              RefReq,
  output logic              RefUrg,
  output logic [OWED_W-1:0] Owed,
  output logic              Overrun
);

  localparam logic [OWED_W-1:0] MAX_O = OWED_W'(MAX_OWED);
  localparam logic [OWED_W-1:0] URG_O = OWED_W'(URG_OWED);
  localparam logic [AGE_W-1:0]  URG_A = AGE_W'(URG_AGE);
  localparam logic [GAP_W-1:0]  GAP_L = GAP_W'(GAP);

  logic              tick;
  logic [OWED_W-1:0] owed;
  logic [AGE_W-1:0]  age;
  logic [GAP_W-1:0]  gap_cnt;
  logic              overrun;

  ref_prescaler #(.PERIOD(REF_PERIOD)) u_pre (
    .clk  (CLK),
    .rst  (RST),
    .en   (RefEn),
    .tick (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      owed    <= '0;
      age     <= '0;
      gap_cnt <= '0;
      overrun <= 1'b0;
    end else if (!RefEn) begin
      owed    <= '0;
      age     <= '0;
      gap_cnt <= '0;
    end else begin
      // A slot arriving in the same cycle as an ack cancels out.
      if (tick && !RefAck) begin
        if (owed == MAX_O) overrun <= 1'b1;
        else               owed    <= owed + OWED_W'(1);
      end else if (RefAck && !tick && (owed != '0)) begin
        owed <= owed - OWED_W'(1);
      end

      if (RefAck || (owed == '0)) age <= '0;
      else if (age < URG_A)       age <= age + AGE_W'(1);

      if (RefAck)                gap_cnt <= GAP_L;
      else if (gap_cnt != '0)    gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // Registered-state decode only, so RefAck never reaches the outputs combinationally.
  assign RefReq  = (owed != '0) && (gap_cnt == '0);
  assign RefUrg  = RefReq && ((owed >= URG_O) || (age >= URG_A));
  assign Owed    = owed;
  assign Overrun = overrun;

endmodule

// File: tb/tb_ref_sched.sv
// Bench for ref_sched: segment table of {inputs, cycles, expected outputs} fed through a
// scoreboard queue, plus hand sequences for enable/reset recovery on the long-period instance.
module tb_ref_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, en_a = 1'b0, ack_a = 1'b0;
  logic req_a, urg_a, ovr_a;
  logic [2:0] owed_a;
  logic rst_b = 1'b1, en_b = 1'b0, ack_b = 1'b0;
  logic req_b, urg_b, ovr_b;
  logic [2:0] owed_b;

  ref_sched #(.REF_PERIOD(8), .MAX_OWED(4), .URG_OWED(2), .URG_AGE(256), .GAP(4)) dut_a (
    .CLK(clk), .RST(rst_a), .RefEn(en_a), .RefAck(ack_a),
    .RefReq(req_a), .RefUrg(urg_a), .Owed(owed_a), .Overrun(ovr_a)
  );

  ref_sched #(.REF_PERIOD(64), .MAX_OWED(4), .URG_OWED(2), .URG_AGE(16), .GAP(4)) dut_b (
    .CLK(clk), .RST(rst_b), .RefEn(en_b), .RefAck(ack_b),
    .RefReq(req_b), .RefUrg(urg_b), .Owed(owed_b), .Overrun(ovr_b)
  );

  typedef struct {
    logic       sel;
    logic       rst;
    logic       en;
    logic       ack;
    int         n;
    logic       req;
    logic       urg;
    logic [2:0] owed;
    logic       ovr;
  } vec_t;

  typedef struct {
    int         row;
    logic       sel;
    logic [5:0] exp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic sel, input logic rst, input logic en, input logic ack,
                     input int n, input logic req, input logic urg,
                     input logic [2:0] owed, input logic ovr);
    vec_t v;
    v.sel = sel; v.rst = rst; v.en = en; v.ack = ack; v.n = n;
    v.req = req; v.urg = urg; v.owed = owed; v.ovr = ovr;
    tbl.push_back(v);
  endtask

  task automatic check_out();
    exp_t e;
    logic [5:0] got;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    got = e.sel ? {req_b, urg_b, owed_b, ovr_b} : {req_a, urg_a, owed_a, ovr_a};
    checks++;
    if (got !== e.exp) begin
      errors++;
      $display("FAIL row %0d dut_%s req/urg/owed/ovr got %b/%b/%0d/%b expected %b/%b/%0d/%b",
               e.row, e.sel ? "b" : "a", got[5], got[4], got[3:1], got[0],
               e.exp[5], e.exp[4], e.exp[3:1], e.exp[0]);
    end
  endtask

  // One clock: check the outputs of the previous edge, drive the next inputs, queue the result.
  task automatic cycle(input int row, input logic sel, input logic rst, input logic en,
                       input logic ack, input logic [5:0] exp);
    exp_t e;
    @(negedge clk);
    check_out();
    if (sel) begin
      rst_b = rst; en_b = en; ack_b = ack; ack_a = 1'b0;
    end else begin
      rst_a = rst; en_a = en; ack_a = ack; ack_b = 1'b0;
    end
    e.row = row; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // dut_a: period 8, saturation at 4, urgent at 2 owed
    add(0,1,1,0, 2, 0,0,0,0);
    add(0,0,1,0, 7, 0,0,0,0);
    add(0,0,1,0, 8, 1,0,1,0);
    add(0,0,1,0, 8, 1,1,2,0);
    add(0,0,1,0, 8, 1,1,3,0);
    add(0,0,1,0, 8, 1,1,4,0);
    add(0,0,1,0, 8, 1,1,4,1);
    add(0,0,1,1, 1, 0,0,4,1);
    add(0,0,1,0, 3, 0,0,4,1);
    add(0,0,1,0, 6, 1,1,4,1);
    add(0,0,1,1, 1, 0,0,3,1);
    add(0,0,1,0, 3, 0,0,3,1);
    add(0,0,0,0, 3, 0,0,0,1);
    add(0,1,1,0, 1, 0,0,0,0);
    add(0,0,1,0, 7, 0,0,0,0);
    add(0,0,1,0, 8, 1,0,1,0);
    add(0,0,1,0, 2, 1,1,2,0);
    add(0,0,1,1, 1, 0,0,1,0);
    add(0,0,1,0, 3, 0,0,1,0);
    add(0,0,1,0, 2, 1,0,1,0);
    add(0,0,1,1, 1, 0,0,1,0);
    add(0,0,1,0, 3, 0,0,1,0);
    add(0,0,1,0, 4, 1,0,1,0);
    add(0,0,1,0, 1, 1,1,2,0);
    add(0,0,0,0,20, 0,0,0,0);
    add(0,0,1,0, 7, 0,0,0,0);
    add(0,0,1,0, 8, 1,0,1,0);
    add(0,0,1,0, 8, 1,1,2,0);
    add(0,0,1,0, 8, 1,1,3,0);
    add(0,0,1,1, 1, 0,0,3,0);
    add(0,0,1,0, 2, 0,0,3,0);
    add(0,1,1,0, 1, 0,0,0,0);
    add(0,0,1,0, 7, 0,0,0,0);
    add(0,0,1,0, 1, 1,0,1,0);
    add(0,0,1,1, 1, 0,0,0,0);
    add(0,0,1,1, 1, 0,0,0,0);
    // dut_b: period 64, age threshold 16
    add(1,1,1,0, 2, 0,0,0,0);
    add(1,0,1,0,63, 0,0,0,0);
    add(1,0,1,0,16, 1,0,1,0);
    add(1,0,1,0,11, 1,1,1,0);
    add(1,0,1,1, 1, 0,0,0,0);
    add(1,0,1,0, 2, 0,0,0,0);
    add(1,0,1,1, 1, 0,0,0,0);
    add(1,0,1,0,33, 0,0,0,0);
    add(1,0,1,0, 1, 1,0,1,0);

    for (int i = 0; i < tbl.size(); i++)
      for (int k = 0; k < tbl[i].n; k++)
        cycle(i, tbl[i].sel, tbl[i].rst, tbl[i].en, tbl[i].ack,
              {tbl[i].req, tbl[i].urg, tbl[i].owed, tbl[i].ovr});

    // Enable drop while requesting: outputs low next cycle, full period before the next slot.
    cycle(100, 1, 0, 0, 0, 6'b000000);
    for (int k = 0; k < 63; k++) cycle(101, 1, 0, 1, 0, 6'b000000);
    cycle(102, 1, 0, 1, 0, 6'b100010);
    // Reset together with an ack must win: no gap, timer restarts from the top.
    cycle(103, 1, 1, 1, 1, 6'b000000);
    for (int k = 0; k < 63; k++) cycle(104, 1, 0, 1, 0, 6'b000000);
    cycle(105, 1, 0, 1, 0, 6'b100010);

    @(negedge clk);
    check_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
